dvbc_rs_sequencer: RTL and testbench
====================================

# dvbc_rs_sequencer

Packet sequencer for the DVB-C Reed-Solomon RS(204,188) encoder. It accepts the MPEG-TS byte stream, hunts for and tracks packet sync, and applies the 8-packet superframe sync inversion (0x47 to 0xB8). It drives the encoder's clear, enable and parity-shift controls and merges the 188 data bytes plus 16 parity bytes into one 204-byte output stream with valid/ready flow control. It sits between the TS input interface and the convolutional interleaver.

## Interface
Parameters:
- K, 188: data bytes per packet.
- N, 204: coded bytes per packet (N-K = 16 parity bytes).
- SYNC, 8'h47: TS sync byte; the inverted sync byte is ~SYNC.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  TS byte.
- in_sop  in  1  marks the first byte of a TS packet.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- enc_din  out  8  byte to the encoder (carries the inverted sync when applicable).
- enc_en  out  1  encoder clocks in enc_din this cycle.
- enc_clr  out  1  with enc_en: encoder starts a new codeword (registers treated as zero).
- enc_shift  out  1  encoder shifts out one parity byte this cycle.
- enc_parity  in  8  current parity byte, combinational from the encoder, MSB-first order.
- out_data  out  8  coded byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts.
- out_sop  out  1  first byte of a 204-byte packet.
- out_sof  out  1  first byte of superframe packet 0 (the inverted sync).
- locked  out  1  high outside the HUNT state.
- sync_err  out  1  one-cycle pulse on loss of sync.

## Operation
- Define free = !out_valid || out_ready. Define acc = in_valid && in_ready.
- State machine: HUNT, DATA, PARITY.
- HUNT:
  - in_ready = free.
  - An accepted byte with in_sop && in_data==SYNC starts a packet (byte index 0) and moves to DATA.
  - All other accepted bytes are discarded.
- DATA, byte index idx from 0 to K-1:
  - in_ready = free.
  - Each accepted byte loads the output register and asserts enc_en.
  - At idx 0, enc_clr=1 and out_sop=1.
  - At idx 0 with pkt_cnt==0, the byte is replaced by ~SYNC on both enc_din and out_data, and out_sof=1.
  - After idx K-1 is accepted, move to PARITY and set pkt_cnt = (pkt_cnt+1) mod 8.
- Sync check at idx 0 of every packet after the first:
  - The byte must have in_sop && in_data==SYNC.
  - Otherwise discard it, pulse sync_err, set pkt_cnt=0 and go to HUNT.
  - in_sop at idx 1..K-1 is ignored.
- PARITY:
  - in_ready=0.
  - Each cycle with free=1: out_data=enc_parity, out_valid=1, enc_shift=1.
  - After N-K parity bytes, return to DATA with idx=0.
- locked=0 only in HUNT.
- Reset: state HUNT, idx=0, pkt_cnt=0, parity count 0. All outputs 0: out_valid, out_data, out_sop, out_sof, in_ready, enc_en, enc_clr, enc_shift, sync_err, locked.
- Counter widths: idx is 8 bits; parity count is 5 bits; pkt_cnt is 3 bits.

## Timing
- out_data, out_valid, out_sop and out_sof are registered. Input-to-output latency is 1 cycle.
- in_ready, enc_en, enc_clr, enc_shift and enc_din are combinational in the current cycle. The encoder samples them at the same clock edge that loads the output register.
- When a load does not occur and out_ready=1, out_valid clears next cycle. When out_valid=1 and out_ready=0, the output register holds all fields unchanged.
- Throughput: 204 output cycles per 188 input bytes. in_ready is low for exactly 16 free cycles per packet.
- Simultaneous events:
  - A load and a downstream accept in the same cycle give a continuous stream with no bubble.
  - In PARITY, enc_shift is asserted only when free=1, so back-pressure never loses a parity byte.
- rst mid-packet: everything returns to reset values on the next edge. The partial packet is abandoned and the encoder is re-cleared by the next enc_clr.
- sync_err pulses in the cycle after the bad byte is accepted. locked falls in that same cycle.

## Test plan
- Reset, then 8 back-to-back valid packets of 0x47 followed by the pattern 1..187, with out_ready=1:
  - 8x204 output bytes.
  - The first byte of packet 0 is 0xB8 with out_sof=1; the first bytes of packets 1-7 are 0x47.
  - in_ready is low for 16 cycles after each packet.
  - Parity matches a reference RS(204,188) model.
- Garbage bytes 0x00, 0x47 without in_sop, then a valid packet:
  - The garbage is discarded and locked=0 until the sop+0x47 byte.
  - The packet is output with out_sof=1.
- Random out_ready toggling (50%) across 3 packets:
  - The output sequence is identical to the case with out_ready=1.
  - enc_shift count is exactly 16 per packet.
  - No held output byte changes while stalled.
- Second packet starting with 0x12 and in_sop=1:
  - sync_err pulses once and locked=0.
  - The next valid packet is output with 0xB8 (pkt_cnt reset).
- rst asserted at idx 100 of a packet:
  - The next cycle shows all outputs 0 and locked=0.
  - A following clean packet encodes correctly with out_sof=1.

Source files
------------

// File: rtl/dvbc_rs_sequencer.sv
// Packet sequencer in front of the RS(204,188) encoder: sync hunt/track, 8-packet
// superframe sync inversion, and merging of 188 data bytes with 16 parity bytes.
module dvbc_rs_sequencer #(
    parameter int         K    = 188,
    parameter int         N    = 204,
    parameter logic [7:0] SYNC = 8'h47
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_sop,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] enc_din,
    output logic       enc_en,
    output logic       enc_clr,
    output logic       enc_shift,
    input  logic [7:0] enc_parity,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_sof,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [7:0] SYNC_INV = ~SYNC;
    localparam logic [7:0] IDX_LAST = 8'(K - 1);
    localparam logic [4:0] PAR_LAST = 5'(N - K - 1);

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    state_t     state;
    logic [7:0] idx;
    logic [4:0] par_cnt;
    logic [2:0] pkt_cnt;

    logic free;
    logic acc;
    logic sync_ok;
    logic at_head;
    logic take;
    logic bad_sync;
    logic invert;

    // The encoder samples its controls on the same edge that loads the output register.
    always_comb begin
        free     = !out_valid || out_ready;
        in_ready = !rst && free && (state != PARITY);
        acc      = in_valid && in_ready;
        sync_ok  = in_sop && (in_data == SYNC);
        at_head  = (state == HUNT) || ((state == DATA) && (idx == 8'd0));
        take     = 1'b0;
        bad_sync = 1'b0;
        if (acc) begin
            if (state == HUNT) begin
                take = sync_ok;
            end else if (state == DATA) begin
                take     = (idx != 8'd0) || sync_ok;
                bad_sync = (idx == 8'd0) && !sync_ok;
            end
        end
        invert    = at_head && (pkt_cnt == 3'd0);
        enc_din   = invert ? SYNC_INV : in_data;
        enc_en    = take;
        enc_clr   = take && at_head;
        enc_shift = !rst && (state == PARITY) && free;
        locked    = (state != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= 8'd0;
            par_cnt   <= 5'd0;
            pkt_cnt   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_sof   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= bad_sync;

            // Output register: data load, parity load, drain, or hold under back-pressure.
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= enc_din;
                out_sop   <= at_head;
                out_sof   <= invert;
            end else if (enc_shift) begin
                out_valid <= 1'b1;
                out_data  <= enc_parity;
                out_sop   <= 1'b0;
                out_sof   <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_sof   <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (take) begin
                        state <= DATA;
                        idx   <= 8'd1;
                    end
                end
                DATA: begin
                    if (bad_sync) begin
                        state   <= HUNT;
                        idx     <= 8'd0;
                        pkt_cnt <= 3'd0;
                    end else if (take) begin
                        if (idx == IDX_LAST) begin
                            state   <= PARITY;
                            idx     <= 8'd0;
                            pkt_cnt <= pkt_cnt + 3'd1;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                PARITY: begin
                    if (enc_shift) begin
                        if (par_cnt == PAR_LAST) begin
                            state   <= DATA;
                            par_cnt <= 5'd0;
                        end else begin
                            par_cnt <= par_cnt + 5'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_dvbc_rs_sequencer.sv
// Bench for dvbc_rs_sequencer: randomized flow control against a packet-level model,
// with a behavioural RS(204,188) LFSR encoder attached to the encoder port.
module tb_dvbc_rs_sequencer;

    localparam int K = 188;
    localparam int N = 204;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] in_data   = 8'h00;
    logic       in_sop    = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] enc_din;
    logic       enc_en;
    logic       enc_clr;
    logic       enc_shift;
    logic [7:0] enc_parity;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sop;
    logic       out_sof;
    logic       locked;
    logic       sync_err;

    always #5 clk = ~clk;

    dvbc_rs_sequencer #(.K(K), .N(N), .SYNC(8'h47)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .enc_din    (enc_din),
        .enc_en     (enc_en),
        .enc_clr    (enc_clr),
        .enc_shift  (enc_shift),
        .enc_parity (enc_parity),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_sof    (out_sof),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    // GF(256), primitive polynomial x^8+x^4+x^3+x^2+1, generator roots alpha^0..alpha^15
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    logic [7:0] g [0:16];

    task automatic build_gen();
        logic [7:0] root;
        root = 8'h01;
        for (int j = 0; j <= 16; j++) g[j] = 8'h00;
        g[0] = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
    endtask

    // Encoder stand-in driven by the DUT's control outputs
    logic [7:0] lfsr [0:15];
    logic [7:0] enc_fb;
    assign enc_fb     = enc_din ^ (enc_clr ? 8'h00 : lfsr[15]);
    assign enc_parity = lfsr[15];

    always @(posedge clk) begin
        if (enc_en) begin
            for (int j = 1; j < 16; j++) lfsr[j] <= (enc_clr ? 8'h00 : lfsr[j-1]) ^ gf_mul(enc_fb, g[j]);
            lfsr[0] <= gf_mul(enc_fb, g[0]);
        end else if (enc_shift) begin
            for (int j = 1; j < 16; j++) lfsr[j] <= lfsr[j-1];
            lfsr[0] <= 8'h00;
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
    } in_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       sof;
    } exp_t;

    in_t  inq [$];
    exp_t exq [$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet-level reference: fed each byte in the order the DUT accepts it
    logic       m_locked  = 1'b0;
    int         m_pos     = 0;
    int         m_pkt_cnt = 0;
    int         m_pkts    = 0;
    int         m_errs    = 0;
    logic       m_err_now = 1'b0;
    logic       m_emit    = 1'b0;
    logic [7:0] m_last    = 8'h00;
    logic [7:0] m_rem [0:15];

    task automatic rem_step(input logic [7:0] b);
        logic [7:0] fb;
        fb = b ^ m_rem[0];
        for (int i = 0; i < 15; i++) m_rem[i] = m_rem[i+1] ^ gf_mul(fb, g[15-i]);
        m_rem[15] = gf_mul(fb, g[0]);
    endtask

    task automatic emit(input logic [7:0] d, input logic sop, input logic sof);
        exp_t e;
        e.d = d;
        e.sop = sop;
        e.sof = sof;
        exq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] d, input logic sop);
        logic [7:0] hdr;
        if (!m_locked || m_pos == 0) begin
            if (sop && d == 8'h47) begin
                hdr = (m_pkt_cnt == 0) ? 8'hB8 : 8'h47;
                emit(hdr, 1'b1, m_pkt_cnt == 0);
                for (int i = 0; i < 16; i++) m_rem[i] = 8'h00;
                rem_step(hdr);
                m_locked = 1'b1;
                m_pos    = 1;
                m_emit   = 1'b1;
                m_last   = hdr;
            end else if (m_locked) begin
                m_err_now = 1'b1;
                m_errs++;
                m_locked  = 1'b0;
                m_pkt_cnt = 0;
            end
        end else begin
            emit(d, 1'b0, 1'b0);
            rem_step(d);
            m_emit = 1'b1;
            m_last = d;
            m_pos++;
            if (m_pos == K) begin
                for (int i = 0; i < 16; i++) emit(m_rem[i], 1'b0, 1'b0);
                m_pkt_cnt = (m_pkt_cnt + 1) % 8;
                m_pos = 0;
                m_pkts++;
            end
        end
    endtask

    task automatic model_clear();
        m_locked  = 1'b0;
        m_pos     = 0;
        m_pkt_cnt = 0;
        exq.delete();
    endtask

    int          vpct = 100;
    int          rpct = 100;
    int          rst_left = 0;
    logic        chk_en = 1'b0;
    logic        acc_q = 1'b0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_bus = '0;
    int          n_shift = 0;
    int          n_busy = 0;
    int          n_err_seen = 0;

    task automatic monitor(input logic rst_at_edge);
        exp_t e;
        if (!chk_en) return;
        if (rst_at_edge && rst)
            chk("reset_outs", 32'({out_valid, out_data, out_sop, out_sof, in_ready, enc_en,
                                   enc_clr, enc_shift, sync_err, locked}), 32'd0);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(m_err_now));
        if (m_emit) chk("latency", 32'({out_valid, out_data}), 32'({1'b1, m_last}));
        if (prev_stall && !rst_at_edge)
            chk("stall_hold", 32'({out_valid, out_data, out_sop, out_sof}), 32'(prev_bus));
        if (out_valid && out_ready) begin
            if (exq.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exq.pop_front();
                chk("out_byte", 32'({out_data, out_sop, out_sof}), 32'({e.d, e.sop, e.sof}));
            end
        end
        if (enc_shift) n_shift++;
        if (!rst && locked && !in_ready && (!out_valid || out_ready)) n_busy++;
        if (sync_err) n_err_seen++;
        prev_stall = out_valid && !out_ready;
        prev_bus   = {out_valid, out_data, out_sop, out_sof};
    endtask

    task automatic step();
        logic rst_at_edge;
        @(posedge clk);
        #1;
        rst_at_edge = rst;
        m_emit      = 1'b0;
        m_err_now   = 1'b0;
        if (rst_at_edge) begin
            model_clear();
        end else if (acc_q) begin
            model_byte(inq[0].d, inq[0].sop);
            inq.delete(0);
        end
        rst = (rst_left > 0);
        if (rst_left > 0) rst_left--;
        if (rst) inq.delete();
        in_valid  = (inq.size() > 0) && ($urandom_range(99) < vpct);
        in_data   = in_valid ? inq[0].d : 8'($urandom);
        in_sop    = in_valid ? inq[0].sop : 1'($urandom);
        out_ready = ($urandom_range(99) < rpct);
        @(negedge clk);
        monitor(rst_at_edge);
        acc_q = in_valid && in_ready;
    endtask

    task automatic do_reset();
        rst_left = 2;
        step();
        step();
    endtask

    task automatic push_byte(input logic [7:0] d, input logic sop);
        in_t t;
        t.d = d;
        t.sop = sop;
        inq.push_back(t);
    endtask

    task automatic push_pkt(input logic [7:0] hdr, input logic hdr_sop, input bit rnd);
        push_byte(hdr, hdr_sop);
        for (int i = 1; i < K; i++) begin
            if (rnd) push_byte(8'($urandom), 1'($urandom));
            else     push_byte(8'(i), 1'b0);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((inq.size() > 0 || exq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(inq.size() + exq.size()), 32'd0);
    endtask

    task automatic chk_counts();
        chk("enc_shift_cnt", 32'(n_shift), 32'(16 * m_pkts));
        chk("in_ready_low_cnt", 32'(n_busy), 32'(16 * m_pkts));
        chk("sync_err_cnt", 32'(n_err_seen), 32'(m_errs));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        build_gen();
        for (int i = 0; i < 16; i++) m_rem[i] = 8'h00;

        // power-up reset; third cycle checks the reset state
        rst_left = 3;
        step();
        step();
        chk_en = 1'b1;
        step();

        // 8 back-to-back packets, full superframe, no back-pressure
        vpct = 100;
        rpct = 100;
        for (int p = 0; p < 8; p++) push_pkt(8'h47, 1'b1, 1'b0);
        drain(8 * N + 200);
        chk_counts();

        // garbage before the first sync while hunting
        do_reset();
        push_byte(8'h00, 1'b1);
        push_byte(8'h47, 1'b0);
        push_byte(8'hB8, 1'b1);
        push_byte(8'h47, 1'b0);
        push_pkt(8'h47, 1'b1, 1'b0);
        drain(N + 200);
        chk_counts();

        // random payload, random input gaps and 50% back-pressure
        vpct = 70;
        rpct = 50;
        for (int p = 0; p < 3; p++) push_pkt(8'h47, 1'b1, 1'b1);
        drain(3 * N * 4 + 400);
        chk_counts();

        // bad sync byte on the next packet, then a good packet restarting the superframe
        vpct = 100;
        rpct = 80;
        push_pkt(8'h12, 1'b1, 1'b0);
        push_pkt(8'h47, 1'b1, 1'b1);
        drain(2 * N * 2 + 400);
        chk_counts();

        // reset in the middle of a packet, then a clean packet
        rpct = 100;
        push_pkt(8'h47, 1'b1, 1'b1);
        n = 0;
        while (!(m_locked && m_pos == 100) && n < 2000) begin
            step();
            n++;
        end
        chk("reach_idx100", 32'(m_pos), 32'd100);
        do_reset();
        push_pkt(8'h47, 1'b1, 1'b1);
        drain(N + 200);
        chk_counts();

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
